// File: rtl/phase_window_gen.sv
// Candidate-window buffer and parallel error generator feeding the phase-matching compare tree.
// Loads WIN candidate phases, then emits WIN saturated (query - candidate) errors per accepted query.
module phase_window_gen #(
    parameter int N_IN_ONE   = 4,
    parameter int DEPTH      = 3,
    parameter int DATA_WIDTH = 16,
    parameter int Q_PER_ROW  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] cand_i,
    input  logic                         cand_vld_i,
    output logic                         cand_rdy_o,
    input  logic signed [DATA_WIDTH-1:0] qry_i,
    input  logic                         qry_vld_i,
    output logic                         qry_rdy_o,
    input  logic                         flush_i,
    output logic signed [DATA_WIDTH-1:0] error_o [N_IN_ONE**DEPTH-1:0],
    output logic signed [DATA_WIDTH-1:0] pos_o   [N_IN_ONE**DEPTH-1:0],
    output logic                         vld_o,
    output logic                         row_done_o
);

    localparam int WIN = N_IN_ONE**DEPTH;
    localparam int CW  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int QW  = $clog2(Q_PER_ROW + 1);

    localparam logic signed [DATA_WIDTH-1:0] INVALID = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] MAX_ERR = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_ERR = {1'b1, {(DATA_WIDTH-2){1'b0}}, 1'b1};
    localparam logic signed [DATA_WIDTH:0]   MAX_W   = {2'b00, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH:0]   MIN_W   = {2'b11, {(DATA_WIDTH-2){1'b0}}, 1'b1};

    localparam logic [0:0] ST_LOAD = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]                   state;
    logic [CW-1:0]                ccnt;
    logic [QW-1:0]                qcnt;
    logic signed [DATA_WIDTH-1:0] cand_buf [WIN];

    logic cand_acc_p0;
    logic qry_acc_p0;
    logic last_c_p0;
    logic last_q_p0;

    // Symmetric clamp keeps the most negative code off the output so abs() downstream is safe;
    // an INVALID operand on either side forces the worst error so the lane is never chosen.
    function automatic logic signed [DATA_WIDTH-1:0] sat_err(
        input logic signed [DATA_WIDTH-1:0] q,
        input logic signed [DATA_WIDTH-1:0] c
    );
        logic signed [DATA_WIDTH:0] d;
        d = {q[DATA_WIDTH-1], q} - {c[DATA_WIDTH-1], c};
        if (q == INVALID || c == INVALID) return MAX_ERR;
        if (d > MAX_W) return MAX_ERR;
        if (d < MIN_W) return MIN_ERR;
        return d[DATA_WIDTH-1:0];
    endfunction

    assign cand_rdy_o  = (state == ST_LOAD);
    assign qry_rdy_o   = (state == ST_RUN);
    assign cand_acc_p0 = cand_vld_i && cand_rdy_o;
    assign qry_acc_p0  = qry_vld_i && qry_rdy_o;
    assign last_c_p0   = (ccnt == CW'(WIN - 1));
    assign last_q_p0   = (qcnt == QW'(Q_PER_ROW - 1));

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            state      <= ST_LOAD;
            ccnt       <= '0;
            qcnt       <= '0;
            vld_o      <= 1'b0;
            row_done_o <= 1'b0;
        end else begin
            vld_o      <= qry_acc_p0;
            row_done_o <= qry_acc_p0 && last_q_p0;
            if (cand_acc_p0) begin
                if (last_c_p0) begin
                    ccnt  <= '0;
                    state <= ST_RUN;
                end else begin
                    ccnt <= ccnt + 1'b1;
                end
            end
            if (qry_acc_p0) begin
                if (last_q_p0) begin
                    qcnt  <= '0;
                    state <= ST_LOAD;
                end else begin
                    qcnt <= qcnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cand_acc_p0 && !rst && !flush_i) begin
            cand_buf[ccnt] <= cand_i;
        end
    end

    // p0 -> p1: all WIN lanes registered together with vld_o
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < WIN; k++) begin
                error_o[k] <= '0;
                pos_o[k]   <= '0;
            end
        end else if (qry_acc_p0 && !flush_i) begin
            for (int k = 0; k < WIN; k++) begin
                error_o[k] <= sat_err(qry_i, cand_buf[k]);
                pos_o[k]   <= DATA_WIDTH'(k);
            end
        end
    end

endmodule

// File: tb/tb_phase_window_gen.sv
// Directed bench for phase_window_gen (WIN=64, DATA_WIDTH=16, Q_PER_ROW=4).
// Expected errors come from an integer reference of the saturating subtract.
module tb_phase_window_gen;

    localparam int DW  = 16;
    localparam int WIN = 64;
    localparam int QPR = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] cand_i;
    logic                 cand_vld_i;
    logic                 cand_rdy_o;
    logic signed [DW-1:0] qry_i;
    logic                 qry_vld_i;
    logic                 qry_rdy_o;
    logic                 flush_i;
    logic signed [DW-1:0] error_o [WIN-1:0];
    logic signed [DW-1:0] pos_o   [WIN-1:0];
    logic                 vld_o;
    logic                 row_done_o;

    int n_chk = 0;
    int n_err = 0;
    int mb [WIN];

    phase_window_gen #(
        .N_IN_ONE   (4),
        .DEPTH      (3),
        .DATA_WIDTH (DW),
        .Q_PER_ROW  (QPR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cand_i     (cand_i),
        .cand_vld_i (cand_vld_i),
        .cand_rdy_o (cand_rdy_o),
        .qry_i      (qry_i),
        .qry_vld_i  (qry_vld_i),
        .qry_rdy_o  (qry_rdy_o),
        .flush_i    (flush_i),
        .error_o    (error_o),
        .pos_o      (pos_o),
        .vld_o      (vld_o),
        .row_done_o (row_done_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int ref_err(input int q, input int c);
        int d;
        if (q == -32768 || c == -32768) return 32767;
        d = q - c;
        if (d > 32767) return 32767;
        if (d < -32767) return -32767;
        return d;
    endfunction

    task automatic chk_lanes(input string tag, input int q);
        int bad = 0;
        for (int k = 0; k < WIN; k++) begin
            if (error_o[k] !== 16'(ref_err(q, mb[k]))) bad++;
            if (pos_o[k] !== 16'(k)) bad++;
        end
        chk(tag, bad, 0);
    endtask

    // Loads mb[0..63]; optional random idle gaps. Query side must stay blocked throughout.
    task automatic load_window(input string tag, input bit gaps);
        int bad = 0;
        for (int k = 0; k < WIN; k++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    cand_vld_i = 1'b0;
                    cand_i     = 16'(12345);
                    if (qry_rdy_o !== 1'b0 || vld_o !== 1'b0 || cand_rdy_o !== 1'b1) bad++;
                    tick();
                end
            end
            cand_vld_i = 1'b1;
            cand_i     = 16'(mb[k]);
            if (qry_rdy_o !== 1'b0 || vld_o !== 1'b0 || cand_rdy_o !== 1'b1) bad++;
            tick();
        end
        cand_vld_i = 1'b0;
        chk(tag, bad, 0);
    endtask

    task automatic do_query(input string tag, input int q);
        qry_i     = 16'(q);
        qry_vld_i = 1'b1;
        tick();
        qry_vld_i = 1'b0;
        chk({tag, "_vld"}, 32'(vld_o), 1);
        chk_lanes({tag, "_lanes"}, q);
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    initial begin
        int qv [5];
        rst = 1'b1; flush_i = 1'b0;
        cand_i = '0; cand_vld_i = 1'b0; qry_i = '0; qry_vld_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_cand_rdy", 32'(cand_rdy_o), 1);
        chk("rst_qry_rdy",  32'(qry_rdy_o), 0);
        chk("rst_vld",      32'(vld_o), 0);
        chk("rst_row_done", 32'(row_done_o), 0);
        chk("rst_err0",     error_o[0], 0);
        chk("rst_pos63",    pos_o[63], 0);

        // 1: linear window, single query
        for (int k = 0; k < WIN; k++) mb[k] = 100 * k;
        load_window("t1_load", 1'b0);
        chk("t1_qry_rdy",  32'(qry_rdy_o), 1);
        chk("t1_cand_rdy", 32'(cand_rdy_o), 0);
        do_query("t1_q250", 250);
        chk("t1_err2",  error_o[2], 50);
        chk("t1_err3",  error_o[3], -50);
        chk("t1_err63", error_o[63], -6050);
        chk("t1_pos63", pos_o[63], 63);
        tick();
        chk("t1_vld_low", 32'(vld_o), 0);
        chk("t1_hold",    error_o[2], 50);
        do_flush();
        chk("t1_flush_load", 32'(cand_rdy_o), 1);

        // 2: saturation at both ends
        for (int k = 0; k < WIN; k++) mb[k] = 0;
        mb[0] = -32000; mb[1] = 32000;
        load_window("t2_load", 1'b0);
        do_query("t2_qpos", 32000);
        chk("t2_err0_sat", error_o[0], 32767);
        chk("t2_err1",     error_o[1], 0);
        do_query("t2_qneg", -32000);
        chk("t2_err1_sat", error_o[1], -32767);
        do_flush();

        // 3: INVALID candidate and INVALID query
        for (int k = 0; k < WIN; k++) mb[k] = 7 * k - 200;
        mb[5] = -32768;
        load_window("t3_load", 1'b0);
        do_query("t3_q1000", 1000);
        chk("t3_err5_a", error_o[5], 32767);
        do_query("t3_qinv", -32768);
        chk("t3_err0_inv", error_o[0], 32767);
        do_query("t3_q0", 0);
        chk("t3_err5_b", error_o[5], 32767);
        chk("t3_err6",   error_o[6], -(7 * 6 - 200));
        do_flush();

        // 4: back-to-back queries to row end, held 5th query
        for (int k = 0; k < WIN; k++) mb[k] = 311 * k - 9000;
        load_window("t4_load", 1'b0);
        qv[0] = -100; qv[1] = 20000; qv[2] = -25000; qv[3] = 7; qv[4] = 4444;
        qry_vld_i = 1'b1;
        for (int i = 0; i < QPR; i++) begin
            qry_i = 16'(qv[i]);
            tick();
            chk($sformatf("t4_vld%0d", i), 32'(vld_o), 1);
            chk_lanes($sformatf("t4_lanes%0d", i), qv[i]);
            chk($sformatf("t4_done%0d", i), 32'(row_done_o), (i == QPR - 1) ? 1 : 0);
        end
        chk("t4_qry_rdy_end",  32'(qry_rdy_o), 0);
        chk("t4_cand_rdy_end", 32'(cand_rdy_o), 1);
        qry_i = 16'(qv[4]);
        tick();
        chk("t4_held_vld", 32'(vld_o), 0);
        for (int k = 0; k < WIN; k++) mb[k] = 5000 - 97 * k;
        load_window("t4_reload", 1'b0);
        tick();
        qry_vld_i = 1'b0;
        chk("t4_q5_vld", 32'(vld_o), 1);
        chk_lanes("t4_q5_lanes", qv[4]);
        do_flush();

        // 5: flush during load, during query accept, and with the last load beat
        for (int k = 0; k < 10; k++) begin
            cand_vld_i = 1'b1; cand_i = 16'(999 * k - 3000);
            tick();
        end
        flush_i = 1'b1; cand_i = 16'(12345);
        tick();
        flush_i = 1'b0; cand_vld_i = 1'b0;
        chk("t5_partial_flush", 32'(cand_rdy_o), 1);
        for (int k = 0; k < WIN; k++) mb[k] = 13 * k - 400;
        load_window("t5_load", 1'b0);
        chk("t5_run", 32'(qry_rdy_o), 1);
        do_query("t5_q", -7);
        qry_vld_i = 1'b1; qry_i = 16'(3); flush_i = 1'b1;
        tick();
        qry_vld_i = 1'b0; flush_i = 1'b0;
        chk("t5_fq_vld",      32'(vld_o), 0);
        chk("t5_fq_done",     32'(row_done_o), 0);
        chk("t5_fq_cand_rdy", 32'(cand_rdy_o), 1);
        chk("t5_fq_hold",     error_o[0], ref_err(-7, mb[0]));
        for (int k = 0; k < WIN - 1; k++) begin
            cand_vld_i = 1'b1; cand_i = 16'(k);
            tick();
        end
        cand_i = 16'(63); flush_i = 1'b1;
        tick();
        flush_i = 1'b0; cand_vld_i = 1'b0;
        chk("t5_lastbeat_load", 32'(cand_rdy_o), 1);
        chk("t5_lastbeat_qrdy", 32'(qry_rdy_o), 0);
        for (int k = 0; k < WIN; k++) mb[k] = 20000 - 600 * k;
        load_window("t5_reload", 1'b0);
        do_query("t5_q2", 100);

        // 6: gapped load with query held valid, then reset mid-run
        do_flush();
        for (int k = 0; k < WIN; k++) mb[k] = int'($urandom_range(0, 65535)) - 32768;
        mb[17] = -32768;
        qry_vld_i = 1'b1; qry_i = 16'(1234);
        load_window("t6_load", 1'b1);
        tick();
        chk("t6_vld_a", 32'(vld_o), 1);
        chk_lanes("t6_lanes_a", 1234);
        qry_i = 16'(-5000);
        tick();
        chk_lanes("t6_lanes_b", -5000);
        rst = 1'b1;
        tick();
        rst = 1'b0; qry_vld_i = 1'b0;
        chk("t6_rst_vld",      32'(vld_o), 0);
        chk("t6_rst_done",     32'(row_done_o), 0);
        chk("t6_rst_cand_rdy", 32'(cand_rdy_o), 1);
        chk("t6_rst_qry_rdy",  32'(qry_rdy_o), 0);
        begin
            int nz = 0;
            for (int k = 0; k < WIN; k++) if (error_o[k] !== 16'd0 || pos_o[k] !== 16'd0) nz++;
            chk("t6_rst_data", nz, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
